wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter
Two pipelined Wishbone B4 masters share one slave port; the slave port drives wb_interface directly.

---
 rtl/wb_arbiter_pkg.sv | 35 +++
 rtl/wb_outstanding_counter.sv | 48 ++++
 rtl/wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone B4 pipelined arbiter:
// bus widths, grant state encoding and the default outstanding limit.
package wb_arbiter_pkg;

  // Default number of accepted-but-unacknowledged requests the arbiter tracks.
  localparam int DEFAULT_MAX_OUTSTANDING = 4;

  // Wishbone bus widths.
  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  // Grant state. The grant is held in this register only, so ownership never
  // follows a master's cyc combinationally.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  // Owner encoding for last_owner: 0 = m0, 1 = m1.
  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  // Resolve a simultaneous request: the master that did not own the bus last.
  function automatic arb_state_e tie_winner(input logic last_owner);
    return (last_owner == OWNER_M1) ? GRANT0 : GRANT1;
  endfunction

  // Counter width able to hold 0..max inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/wb_outstanding_counter.sv
// Tracks requests accepted by the slave but not yet acknowledged.
// Increments are refused when full, decrements are refused when empty, so a
// stray acknowledge can never underflow the count.
module wb_outstanding_counter
  import wb_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             inc_ok;
  logic             dec_ok;

  assign full   = (count_reg == CNT_W'(MAX_OUTSTANDING));
  assign empty  = (count_reg == '0);
  assign inc_ok = inc & ~full;
  assign dec_ok = dec & ~empty;

  // Next count: simultaneous accept and acknowledge cancel out.
  always_comb begin
    count_next = count_reg;
    case ({inc_ok, dec_ok})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Count register; reset discards any in-flight transactions.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two pipelined Wishbone B4 masters sharing one slave port. Ownership is
// granted by a registered FSM with alternating priority on ties; the owner
// keeps the bus until it drops cyc and every accepted request is acked.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // master 0
  input  logic [WB_ADR_W-1:0] m0_wb_adr_i,
  input  logic [WB_DAT_W-1:0] m0_wb_dat_i,
  output logic [WB_DAT_W-1:0] m0_wb_dat_o,
  input  logic                m0_wb_we_i,
  input  logic [WB_SEL_W-1:0] m0_wb_sel_i,
  input  logic                m0_wb_stb_i,
  input  logic                m0_wb_cyc_i,
  output logic                m0_wb_ack_o,
  output logic                m0_wb_stall_o,
  // master 1
  input  logic [WB_ADR_W-1:0] m1_wb_adr_i,
  input  logic [WB_DAT_W-1:0] m1_wb_dat_i,
  output logic [WB_DAT_W-1:0] m1_wb_dat_o,
  input  logic                m1_wb_we_i,
  input  logic [WB_SEL_W-1:0] m1_wb_sel_i,
  input  logic                m1_wb_stb_i,
  input  logic                m1_wb_cyc_i,
  output logic                m1_wb_ack_o,
  output logic                m1_wb_stall_o,
  // slave port
  output logic [WB_ADR_W-1:0] s_wb_adr_o,
  output logic [WB_DAT_W-1:0] s_wb_dat_o,
  input  logic [WB_DAT_W-1:0] s_wb_dat_i,
  output logic                s_wb_we_o,
  output logic                s_wb_stb_o,
  output logic                s_wb_cyc_o,
  output logic [WB_SEL_W-1:0] s_wb_sel_o,
  input  logic                s_wb_ack_i,
  input  logic                s_wb_stall_i
);

  arb_state_e state_reg;
  logic       last_owner_reg;

  logic       full;
  logic       empty;
  logic       accept;

  // A request is accepted when it reaches the slave and the slave is not stalling.
  assign accept = s_wb_stb_o & ~s_wb_stall_i;

  wb_outstanding_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_outstanding (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc  (accept),
    .dec  (s_wb_ack_i),
    .full (full),
    .empty(empty)
  );

  // Grant FSM: IDLE picks an owner, GRANTx holds until the owner is done and drained.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg      <= IDLE;
      last_owner_reg <= OWNER_M1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (m0_wb_cyc_i && m1_wb_cyc_i) begin
            state_reg <= tie_winner(last_owner_reg);
          end else if (m0_wb_cyc_i) begin
            state_reg <= GRANT0;
          end else if (m1_wb_cyc_i) begin
            state_reg <= GRANT1;
          end
        end
        GRANT0: begin
          if (!m0_wb_cyc_i && empty) begin
            state_reg      <= IDLE;
            last_owner_reg <= OWNER_M0;
          end
        end
        GRANT1: begin
          if (!m1_wb_cyc_i && empty) begin
            state_reg      <= IDLE;
            last_owner_reg <= OWNER_M1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Read data fans out to both masters; only the owner sees an ack.
  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;

  // Slave-side mux and master handshake routing driven by the registered grant.
  always_comb begin
    s_wb_adr_o    = '0;
    s_wb_dat_o    = '0;
    s_wb_we_o     = 1'b0;
    s_wb_sel_o    = '0;
    s_wb_stb_o    = 1'b0;
    s_wb_cyc_o    = 1'b0;
    m0_wb_stall_o = 1'b1;
    m1_wb_stall_o = 1'b1;
    m0_wb_ack_o   = 1'b0;
    m1_wb_ack_o   = 1'b0;
    case (state_reg)
      GRANT0: begin
        s_wb_adr_o    = m0_wb_adr_i;
        s_wb_dat_o    = m0_wb_dat_i;
        s_wb_we_o     = m0_wb_we_i;
        s_wb_sel_o    = m0_wb_sel_i;
        // Cycle stays open after cyc drops until every accepted request is acked.
        s_wb_cyc_o    = m0_wb_cyc_i | ~empty;
        s_wb_stb_o    = m0_wb_stb_i & m0_wb_cyc_i & ~full;
        m0_wb_stall_o = s_wb_stall_i | full;
        // Acks with nothing outstanding are dropped rather than forwarded.
        m0_wb_ack_o   = s_wb_ack_i & ~empty;
      end
      GRANT1: begin
        s_wb_adr_o    = m1_wb_adr_i;
        s_wb_dat_o    = m1_wb_dat_i;
        s_wb_we_o     = m1_wb_we_i;
        s_wb_sel_o    = m1_wb_sel_i;
        s_wb_cyc_o    = m1_wb_cyc_i | ~empty;
        s_wb_stb_o    = m1_wb_stb_i & m1_wb_cyc_i & ~full;
        m1_wb_stall_o = s_wb_stall_i | full;
        m1_wb_ack_o   = s_wb_ack_i & ~empty;
      end
      default: begin
        s_wb_cyc_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter. Stimulus pushes expected slave requests and
// master acks into queues; a negedge monitor pops and compares them.
module tb_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m0_wb_adr_i, m0_wb_dat_i, m0_wb_dat_o;
  logic        m0_wb_we_i, m0_wb_stb_i, m0_wb_cyc_i, m0_wb_ack_o, m0_wb_stall_o;
  logic [3:0]  m0_wb_sel_i;
  logic [31:0] m1_wb_adr_i, m1_wb_dat_i, m1_wb_dat_o;
  logic        m1_wb_we_i, m1_wb_stb_i, m1_wb_cyc_i, m1_wb_ack_o, m1_wb_stall_o;
  logic [3:0]  m1_wb_sel_i;
  logic [31:0] s_wb_adr_o, s_wb_dat_o, s_wb_dat_i;
  logic        s_wb_we_o, s_wb_stb_o, s_wb_cyc_o, s_wb_ack_i, s_wb_stall_i;
  logic [3:0]  s_wb_sel_o;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } req_t;

  typedef struct packed {
    logic        mst;
    logic [31:0] dat;
  } ack_t;

  req_t req_q[$];
  ack_t ack_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk_i = ~clk_i;

  wb_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .m0_wb_adr_i  (m0_wb_adr_i),
    .m0_wb_dat_i  (m0_wb_dat_i),
    .m0_wb_dat_o  (m0_wb_dat_o),
    .m0_wb_we_i   (m0_wb_we_i),
    .m0_wb_sel_i  (m0_wb_sel_i),
    .m0_wb_stb_i  (m0_wb_stb_i),
    .m0_wb_cyc_i  (m0_wb_cyc_i),
    .m0_wb_ack_o  (m0_wb_ack_o),
    .m0_wb_stall_o(m0_wb_stall_o),
    .m1_wb_adr_i  (m1_wb_adr_i),
    .m1_wb_dat_i  (m1_wb_dat_i),
    .m1_wb_dat_o  (m1_wb_dat_o),
    .m1_wb_we_i   (m1_wb_we_i),
    .m1_wb_sel_i  (m1_wb_sel_i),
    .m1_wb_stb_i  (m1_wb_stb_i),
    .m1_wb_cyc_i  (m1_wb_cyc_i),
    .m1_wb_ack_o  (m1_wb_ack_o),
    .m1_wb_stall_o(m1_wb_stall_o),
    .s_wb_adr_o   (s_wb_adr_o),
    .s_wb_dat_o   (s_wb_dat_o),
    .s_wb_dat_i   (s_wb_dat_i),
    .s_wb_we_o    (s_wb_we_o),
    .s_wb_stb_o   (s_wb_stb_o),
    .s_wb_cyc_o   (s_wb_cyc_o),
    .s_wb_sel_o   (s_wb_sel_o),
    .s_wb_ack_i   (s_wb_ack_i),
    .s_wb_stall_i (s_wb_stall_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%b want=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input logic [31:0] adr, input logic [31:0] dat,
                          input logic we, input logic [3:0] sel);
    req_t r;
    r.adr = adr;
    r.dat = dat;
    r.we  = we;
    r.sel = sel;
    req_q.push_back(r);
  endtask

  task automatic push_ack(input logic mst, input logic [31:0] dat);
    ack_t a;
    a.mst = mst;
    a.dat = dat;
    ack_q.push_back(a);
  endtask

  task automatic clear_inputs();
    m0_wb_adr_i = '0; m0_wb_dat_i = '0; m0_wb_we_i = 1'b0; m0_wb_sel_i = '0;
    m0_wb_stb_i = 1'b0; m0_wb_cyc_i = 1'b0;
    m1_wb_adr_i = '0; m1_wb_dat_i = '0; m1_wb_we_i = 1'b0; m1_wb_sel_i = '0;
    m1_wb_stb_i = 1'b0; m1_wb_cyc_i = 1'b0;
    s_wb_dat_i = '0; s_wb_ack_i = 1'b0; s_wb_stall_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
  endtask

  // Monitor: every accepted slave request and every master ack consumes one expectation.
  always @(negedge clk_i) begin
    req_t r;
    ack_t a;
    logic [31:0] got_dat;
    if (rst_i) begin
      if (s_wb_stb_o && !s_wb_stall_i) begin
        total = total + 1;
        if (req_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL req_unexpected got adr=%h dat=%h we=%b sel=%b", s_wb_adr_o, s_wb_dat_o, s_wb_we_o, s_wb_sel_o);
        end else begin
          r = req_q.pop_front();
          if ({s_wb_adr_o, s_wb_dat_o, s_wb_we_o, s_wb_sel_o} !== r) begin
            bad = bad + 1;
            $display("FAIL req got adr=%h dat=%h we=%b sel=%b want adr=%h dat=%h we=%b sel=%b",
                     s_wb_adr_o, s_wb_dat_o, s_wb_we_o, s_wb_sel_o, r.adr, r.dat, r.we, r.sel);
          end else begin
            $display("txn req adr=%h dat=%h we=%b sel=%b ok", r.adr, r.dat, r.we, r.sel);
          end
        end
      end
      if (m0_wb_ack_o || m1_wb_ack_o) begin
        total = total + 1;
        got_dat = m1_wb_ack_o ? m1_wb_dat_o : m0_wb_dat_o;
        if (m0_wb_ack_o && m1_wb_ack_o) begin
          bad = bad + 1;
          $display("FAIL ack_both got m0=1 m1=1 want one master");
        end else if (ack_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL ack_unexpected got m%0d dat=%h want none", m1_wb_ack_o, got_dat);
        end else begin
          a = ack_q.pop_front();
          if ({m1_wb_ack_o, got_dat} !== a) begin
            bad = bad + 1;
            $display("FAIL ack got m%0d dat=%h want m%0d dat=%h", m1_wb_ack_o, got_dat, a.mst, a.dat);
          end else begin
            $display("txn ack m%0d dat=%h ok", a.mst, a.dat);
          end
        end
      end
    end
  end

  initial begin
    clear_inputs();
    rst_i = 1'b0;
    tick();
    tick();
    settle();
    chk1("rst_s_cyc", s_wb_cyc_o, 1'b0);
    chk1("rst_s_stb", s_wb_stb_o, 1'b0);
    chk1("rst_s_we", s_wb_we_o, 1'b0);
    chk1("rst_m0_stall", m0_wb_stall_o, 1'b1);
    chk1("rst_m1_stall", m1_wb_stall_o, 1'b1);
    chk1("rst_m0_ack", m0_wb_ack_o, 1'b0);
    chk1("rst_m1_ack", m1_wb_ack_o, 1'b0);
    rst_i = 1'b1;

    // single read by m0
    tick();
    m0_wb_cyc_i = 1'b1;
    settle();
    chk1("t1_no_comb_grant", m0_wb_stall_o, 1'b1);
    tick();
    m0_wb_stb_i = 1'b1; m0_wb_adr_i = 32'h10; m0_wb_sel_i = 4'hF;
    push_req(32'h10, 32'h0, 1'b0, 4'hF);
    settle();
    chk1("t1_granted_stall", m0_wb_stall_o, 1'b0);
    tick();
    m0_wb_stb_i = 1'b0; s_wb_ack_i = 1'b1; s_wb_dat_i = 32'hDEADBEEF;
    push_ack(1'b0, 32'hDEADBEEF);
    settle();
    chk32("t1_read_data", m0_wb_dat_o, 32'hDEADBEEF);
    tick();
    s_wb_ack_i = 1'b0; m0_wb_cyc_i = 1'b0;
    settle();
    chk1("t1_ack_one_cycle", m0_wb_ack_o, 1'b0);
    chk1("t1_cyc_drop", s_wb_cyc_o, 1'b0);
    tick();
    settle();
    chk1("t1_idle_stall", m0_wb_stall_o, 1'b1);

    // tie from reset, then alternation
    do_reset();
    tick();
    m0_wb_cyc_i = 1'b1; m1_wb_cyc_i = 1'b1;
    tick();
    settle();
    chk1("t2_tie_m0_stall", m0_wb_stall_o, 1'b0);
    chk1("t2_tie_m1_stall", m1_wb_stall_o, 1'b1);
    m0_wb_cyc_i = 1'b0;
    tick();
    settle();
    chk1("t2_gap_m1_stall", m1_wb_stall_o, 1'b1);
    chk1("t2_gap_s_cyc", s_wb_cyc_o, 1'b0);
    tick();
    m1_wb_stb_i = 1'b1; m1_wb_adr_i = 32'h20; m1_wb_sel_i = 4'hF;
    push_req(32'h20, 32'h0, 1'b0, 4'hF);
    settle();
    chk1("t2_g1_m1_stall", m1_wb_stall_o, 1'b0);
    chk1("t2_g1_m0_stall", m0_wb_stall_o, 1'b1);
    tick();
    m1_wb_stb_i = 1'b0; s_wb_ack_i = 1'b1; s_wb_dat_i = 32'hCAFE0001;
    push_ack(1'b1, 32'hCAFE0001);
    tick();
    s_wb_ack_i = 1'b0; m1_wb_cyc_i = 1'b0;
    tick();
    m0_wb_cyc_i = 1'b1; m1_wb_cyc_i = 1'b1;
    tick();
    settle();
    chk1("t2_alt_m0_stall", m0_wb_stall_o, 1'b0);
    chk1("t2_alt_m1_stall", m1_wb_stall_o, 1'b1);
    m0_wb_cyc_i = 1'b0; m1_wb_cyc_i = 1'b0;
    tick();
    m0_wb_cyc_i = 1'b1; m1_wb_cyc_i = 1'b1;
    tick();
    settle();
    chk1("t2_alt2_m1_stall", m1_wb_stall_o, 1'b0);
    chk1("t2_alt2_m0_stall", m0_wb_stall_o, 1'b1);
    m0_wb_cyc_i = 1'b0; m1_wb_cyc_i = 1'b0;

    // outstanding limit with a silent slave
    do_reset();
    tick();
    m1_wb_cyc_i = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      m1_wb_stb_i = 1'b1; m1_wb_sel_i = 4'hF;
      m1_wb_adr_i = 32'h100 + 32'((i < 4) ? i : 4);
      if (i < 4) push_req(32'h100 + 32'(i), 32'h0, 1'b0, 4'hF);
      if (i == 5) begin
        s_wb_ack_i = 1'b1; s_wb_dat_i = 32'hAAAA0005;
        push_ack(1'b1, 32'hAAAA0005);
      end
      settle();
      chk1($sformatf("t3_stall_%0d", i), m1_wb_stall_o, (i >= 4));
    end
    tick();
    s_wb_ack_i = 1'b0;
    push_req(32'h104, 32'h0, 1'b0, 4'hF);
    settle();
    chk1("t3_after_ack_stall", m1_wb_stall_o, 1'b0);
    tick();
    m1_wb_stb_i = 1'b0;
    settle();
    chk1("t3_full_again", m1_wb_stall_o, 1'b1);

    // drain after master drops cyc
    do_reset();
    tick();
    m0_wb_cyc_i = 1'b1;
    tick();
    m0_wb_stb_i = 1'b1; m0_wb_we_i = 1'b1; m0_wb_sel_i = 4'h3;
    m0_wb_adr_i = 32'h200; m0_wb_dat_i = 32'h11;
    push_req(32'h200, 32'h11, 1'b1, 4'h3);
    tick();
    m0_wb_adr_i = 32'h204; m0_wb_dat_i = 32'h22;
    push_req(32'h204, 32'h22, 1'b1, 4'h3);
    tick();
    m0_wb_cyc_i = 1'b0;
    settle();
    chk1("t4_drain_cyc", s_wb_cyc_o, 1'b1);
    chk1("t4_drain_stb", s_wb_stb_o, 1'b0);
    tick();
    m0_wb_stb_i = 1'b0; s_wb_ack_i = 1'b1; s_wb_dat_i = 32'hA1;
    push_ack(1'b0, 32'hA1);
    settle();
    chk1("t4_drain_cyc_ack1", s_wb_cyc_o, 1'b1);
    tick();
    s_wb_dat_i = 32'hA2;
    push_ack(1'b0, 32'hA2);
    settle();
    chk1("t4_drain_cyc_ack2", s_wb_cyc_o, 1'b1);
    tick();
    s_wb_ack_i = 1'b0;
    settle();
    chk1("t4_drained_cyc", s_wb_cyc_o, 1'b0);
    tick();
    settle();
    chk1("t4_idle_stall", m0_wb_stall_o, 1'b1);

    // asynchronous reset mid-burst
    do_reset();
    tick();
    m0_wb_cyc_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      m0_wb_stb_i = 1'b1; m0_wb_sel_i = 4'hF; m0_wb_adr_i = 32'h400 + 32'(i);
      push_req(32'h400 + 32'(i), 32'h0, 1'b0, 4'hF);
    end
    tick();
    rst_i = 1'b0;
    #1;
    chk1("t5_rst_cyc", s_wb_cyc_o, 1'b0);
    chk1("t5_rst_stb", s_wb_stb_o, 1'b0);
    chk1("t5_rst_stall", m0_wb_stall_o, 1'b1);
    tick();
    m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0; rst_i = 1'b1;
    tick();
    s_wb_ack_i = 1'b1;
    settle();
    chk1("t5_stray_idle_m0", m0_wb_ack_o, 1'b0);
    chk1("t5_stray_idle_m1", m1_wb_ack_o, 1'b0);
    tick();
    s_wb_ack_i = 1'b0; m0_wb_cyc_i = 1'b1;
    tick();
    s_wb_ack_i = 1'b1;
    settle();
    chk1("t5_stray_grant_m0", m0_wb_ack_o, 1'b0);
    tick();
    s_wb_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      m0_wb_stb_i = 1'b1; m0_wb_adr_i = 32'h500 + 32'((i < 4) ? i : 4);
      if (i < 4) push_req(32'h500 + 32'(i), 32'h0, 1'b0, 4'hF);
      settle();
      chk1($sformatf("t5_count_stall_%0d", i), m0_wb_stall_o, (i >= 4));
    end
    tick();
    m0_wb_stb_i = 1'b0; m0_wb_cyc_i = 1'b0;

    // m1 write while m0 waits
    do_reset();
    tick();
    m1_wb_cyc_i = 1'b1;
    tick();
    m0_wb_cyc_i = 1'b1;
    m1_wb_stb_i = 1'b1; m1_wb_we_i = 1'b1; m1_wb_sel_i = 4'b0101;
    m1_wb_adr_i = 32'h300; m1_wb_dat_i = 32'h12345678;
    s_wb_stall_i = 1'b1;
    settle();
    chk1("t6_slave_stall_m1", m1_wb_stall_o, 1'b1);
    chk1("t6_wait_m0_a", m0_wb_stall_o, 1'b1);
    tick();
    s_wb_stall_i = 1'b0;
    push_req(32'h300, 32'h12345678, 1'b1, 4'b0101);
    settle();
    chk1("t6_wait_m0_b", m0_wb_stall_o, 1'b1);
    tick();
    m1_wb_stb_i = 1'b0; s_wb_ack_i = 1'b1; s_wb_dat_i = 32'h0;
    push_ack(1'b1, 32'h0);
    settle();
    chk1("t6_wait_m0_c", m0_wb_stall_o, 1'b1);
    tick();
    s_wb_ack_i = 1'b0; m1_wb_cyc_i = 1'b0;
    settle();
    chk1("t6_wait_m0_d", m0_wb_stall_o, 1'b1);
    tick();
    settle();
    chk1("t6_gap_m0", m0_wb_stall_o, 1'b1);
    tick();
    settle();
    chk1("t6_m0_granted", m0_wb_stall_o, 1'b0);
    m0_wb_cyc_i = 1'b0;
    tick();
    tick();

    chk32("req_queue_empty", 32'(req_q.size()), 32'd0);
    chk32("ack_queue_empty", 32'(ack_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
